// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - instruction fetch stage: PC, IF/ID register, redirect/trap entry and fetch-fault reporting
module fetch_stage #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int unsigned IMEM_BYTES = 1 << 20,
  parameter logic [31:0] NOP_INSTR  = 32'h0000_0013
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_stall,
  input  logic        i_flush,
  input  logic        i_redirect_valid,
  input  logic [31:0] i_redirect_pc,
  input  logic        i_trap_valid,
  input  logic [31:0] i_trap_pc,
  output logic [31:0] o_imem_adr,
  input  logic [31:0] i_imem_instr,
  output logic        o_if_id_valid,
  output logic [31:0] o_if_id_pc,
  output logic [31:0] o_if_id_pc_plus4,
  output logic [31:0] o_if_id_instr,
  output logic        o_fault,
  output logic [3:0]  o_fault_cause,
  output logic [31:0] o_fault_tval,
  output logic [31:0] o_fetch_count
);

  localparam logic [31:0] LAST_FETCH       = 32'(IMEM_BYTES - 4);
  localparam logic [3:0]  CAUSE_MISALIGNED = 4'd0;
  localparam logic [3:0]  CAUSE_ACCESS     = 4'd1;

  typedef enum logic {RUN = 1'b0, WAIT_TRAP = 1'b1} state_t;
  state_t state, state_nxt;

  logic [31:0] pc, pc_plus4, pc_nxt, trap_target;
  logic        redirect_misaligned, pc_out_of_range;
  logic        load_bubble, load_instr, fault_set;
  logic [3:0]  cause_nxt;
  logic [31:0] tval_nxt;

  assign pc_plus4            = pc + 32'd4;
  assign trap_target         = i_trap_pc & 32'hFFFF_FFFC;
  assign redirect_misaligned = i_redirect_pc[1:0] != 2'b00;
  assign pc_out_of_range     = pc > LAST_FETCH;
  assign o_imem_adr          = pc;

  always_ff @(posedge i_clk) begin
    if (i_rst) state <= RUN;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (i_trap_valid) begin
      state_nxt = RUN;
    end else if (i_redirect_valid) begin
      if (redirect_misaligned) state_nxt = WAIT_TRAP;
    end else if (state == RUN && !i_stall && pc_out_of_range) begin
      state_nxt = WAIT_TRAP;
    end
  end

  // Priority chain choosing what this edge does to PC, IF/ID and the fault record.
  always_comb begin
    pc_nxt      = pc;
    load_bubble = 1'b0;
    load_instr  = 1'b0;
    fault_set   = 1'b0;
    cause_nxt   = CAUSE_MISALIGNED;
    tval_nxt    = i_redirect_pc;
    if (i_trap_valid) begin
      pc_nxt      = trap_target;
      load_bubble = 1'b1;
    end else if (i_redirect_valid) begin
      load_bubble = 1'b1;
      if (redirect_misaligned) begin
        fault_set = 1'b1;
        cause_nxt = CAUSE_MISALIGNED;
        tval_nxt  = i_redirect_pc;
      end else begin
        pc_nxt = i_redirect_pc;
      end
    end else if (state == WAIT_TRAP) begin
      load_bubble = 1'b1;
    end else if (!i_stall && pc_out_of_range) begin
      load_bubble = 1'b1;
      fault_set   = 1'b1;
      cause_nxt   = CAUSE_ACCESS;
      tval_nxt    = pc;
    end else if (i_flush) begin
      load_bubble = 1'b1;
      if (!i_stall) pc_nxt = pc_plus4;
    end else if (!i_stall) begin
      load_instr = 1'b1;
      pc_nxt     = pc_plus4;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      pc               <= RESET_PC;
      o_if_id_valid    <= 1'b0;
      o_if_id_pc       <= 32'h0;
      o_if_id_pc_plus4 <= 32'h0;
      o_if_id_instr    <= NOP_INSTR;
      o_fault          <= 1'b0;
      o_fault_cause    <= 4'h0;
      o_fault_tval     <= 32'h0;
      o_fetch_count    <= 32'h0;
    end else begin
      pc      <= pc_nxt;
      o_fault <= fault_set;
      if (fault_set) begin
        o_fault_cause <= cause_nxt;
        o_fault_tval  <= tval_nxt;
      end
      if (load_bubble) begin
        o_if_id_valid    <= 1'b0;
        o_if_id_pc       <= pc;
        o_if_id_pc_plus4 <= pc_plus4;
        o_if_id_instr    <= NOP_INSTR;
      end else if (load_instr) begin
        o_if_id_valid    <= 1'b1;
        o_if_id_pc       <= pc;
        o_if_id_pc_plus4 <= pc_plus4;
        o_if_id_instr    <= i_imem_instr;
        o_fetch_count    <= o_fetch_count + 32'd1;
      end
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// tb/tb_fetch_stage.sv - directed and randomized checks of fetch_stage against a behavioural model
module tb_fetch_stage;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, stall, flush, rv, tv;
  logic [31:0] rpc, tpc;
  logic [31:0] imem_adr, imem_instr, ifid_pc, ifid_pc4, ifid_instr, tval, count;
  logic        ifid_valid, fault;
  logic [3:0]  cause;
  int total = 0;
  int bad = 0;

  logic [31:0] m_pc, m_ipc, m_ipc4, m_instr, m_tval, m_count;
  logic        m_wait, m_valid, m_fault;
  logic [3:0]  m_cause;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    case (a)
      32'h0:   return 32'h00500093;
      32'h4:   return 32'h00A00113;
      32'h8:   return 32'h002081B3;
      32'hC:   return 32'h00000013;
      default: return {a[15:0], a[31:16]} ^ 32'h1357_9BDF;
    endcase
  endfunction

  assign imem_instr = mem_word(imem_adr);

  fetch_stage dut (
    .i_clk(clk), .i_rst(rst), .i_stall(stall), .i_flush(flush),
    .i_redirect_valid(rv), .i_redirect_pc(rpc),
    .i_trap_valid(tv), .i_trap_pc(tpc),
    .o_imem_adr(imem_adr), .i_imem_instr(imem_instr),
    .o_if_id_valid(ifid_valid), .o_if_id_pc(ifid_pc),
    .o_if_id_pc_plus4(ifid_pc4), .o_if_id_instr(ifid_instr),
    .o_fault(fault), .o_fault_cause(cause), .o_fault_tval(tval),
    .o_fetch_count(count)
  );

  // One edge of the fetch stage as described in prose: highest-priority event wins.
  task automatic model_step();
    logic [31:0] cur;
    logic bubble;
    cur = m_pc;
    bubble = 1'b1;
    m_fault = 1'b0;
    if (rst) begin
      m_pc = 32'h0; m_wait = 1'b0; m_valid = 1'b0; m_instr = NOP;
      m_ipc = 32'h0; m_ipc4 = 32'h0; m_cause = 4'h0; m_tval = 32'h0; m_count = 32'h0;
    end else begin
      if (tv) begin
        m_pc = {tpc[31:2], 2'b00};
        m_wait = 1'b0;
      end else if (rv && rpc[1:0] != 2'b00) begin
        m_wait = 1'b1; m_fault = 1'b1; m_cause = 4'd0; m_tval = rpc;
      end else if (rv) begin
        m_pc = rpc;
      end else if (m_wait) begin
        bubble = 1'b1;
      end else if (!stall && cur > 32'h000F_FFFC) begin
        m_wait = 1'b1; m_fault = 1'b1; m_cause = 4'd1; m_tval = cur;
      end else if (flush) begin
        if (!stall) m_pc = cur + 32'd4;
      end else if (stall) begin
        bubble = 1'b0;
      end else begin
        m_valid = 1'b1; m_ipc = cur; m_ipc4 = cur + 32'd4; m_instr = mem_word(cur);
        m_pc = cur + 32'd4; m_count = m_count + 32'd1;
        bubble = 1'b0;
      end
      if (bubble) begin
        m_valid = 1'b0; m_ipc = cur; m_ipc4 = cur + 32'd4; m_instr = NOP;
      end
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic r, input logic s, input logic f, input logic redir,
                       input logic [31:0] rp, input logic trp, input logic [31:0] tp);
    rst = r; stall = s; flush = f; rv = redir; rpc = rp; tv = trp; tpc = tp;
  endtask

  task automatic test_reset();
    drive(1, 0, 0, 0, 32'h0, 0, 32'h0);
    tick();
    total++;
    if ({imem_adr, ifid_valid, ifid_pc, ifid_pc4, ifid_instr, fault, cause, tval, count} !==
        {32'h0, 1'b0, 32'h0, 32'h0, NOP, 1'b0, 4'h0, 32'h0, 32'h0}) begin
      bad++;
      $display("FAIL reset: adr=%h v=%b pc=%h pc4=%h instr=%h f=%b c=%h tval=%h cnt=%h, want zeros and instr %h",
               imem_adr, ifid_valid, ifid_pc, ifid_pc4, ifid_instr, fault, cause, tval, count, NOP);
    end
  endtask

  task automatic test_free_run();
    logic [31:0] words [4];
    words[0] = 32'h00500093; words[1] = 32'h00A00113; words[2] = 32'h002081B3; words[3] = 32'h00000013;
    drive(0, 0, 0, 0, 32'h0, 0, 32'h0);
    for (int i = 0; i < 4; i++) begin
      tick();
      total++;
      if ({ifid_valid, ifid_pc, ifid_pc4, ifid_instr} !== {1'b1, 32'(4 * i), 32'(4 * i + 4), words[i]}) begin
        bad++;
        $display("FAIL free_run slot %0d: got v=%b pc=%h pc4=%h instr=%h want pc=%h instr=%h",
                 i, ifid_valid, ifid_pc, ifid_pc4, ifid_instr, 4 * i, words[i]);
      end
    end
    total++;
    if (count !== 32'd4) begin
      bad++;
      $display("FAIL free_run count: got %0d want 4", count);
    end
  endtask

  task automatic test_stall();
    drive(1, 0, 0, 0, 32'h0, 0, 32'h0);
    tick();
    drive(0, 0, 0, 0, 32'h0, 0, 32'h0);
    tick();
    tick();
    drive(0, 1, 0, 0, 32'h0, 0, 32'h0);
    for (int i = 0; i < 3; i++) begin
      tick();
      total++;
      if ({imem_adr, ifid_valid, ifid_pc, ifid_instr, count} !== {32'h8, 1'b1, 32'h4, 32'h00A00113, 32'd2}) begin
        bad++;
        $display("FAIL stall cycle %0d: adr=%h v=%b pc=%h instr=%h cnt=%0d want adr=8 pc=4 instr=00a00113 cnt=2",
                 i, imem_adr, ifid_valid, ifid_pc, ifid_instr, count);
      end
    end
    drive(0, 0, 0, 0, 32'h0, 0, 32'h0);
    tick();
    total++;
    if ({ifid_pc, ifid_instr, count} !== {32'h8, 32'h002081B3, 32'd3}) begin
      bad++;
      $display("FAIL stall resume: pc=%h instr=%h cnt=%0d want pc=8 instr=002081b3 cnt=3", ifid_pc, ifid_instr, count);
    end
  endtask

  task automatic test_redirect_stall();
    drive(0, 1, 0, 1, 32'h40, 0, 32'h0);
    tick();
    total++;
    if ({imem_adr, ifid_valid, ifid_instr} !== {32'h40, 1'b0, NOP}) begin
      bad++;
      $display("FAIL redirect_stall: adr=%h v=%b instr=%h want adr=40 v=0 instr=%h", imem_adr, ifid_valid, ifid_instr, NOP);
    end
    drive(0, 0, 0, 0, 32'h0, 0, 32'h0);
    tick();
    total++;
    if ({ifid_valid, ifid_pc, ifid_instr} !== {1'b1, 32'h40, mem_word(32'h40)}) begin
      bad++;
      $display("FAIL redirect_target: v=%b pc=%h instr=%h want pc=40", ifid_valid, ifid_pc, ifid_instr);
    end
  endtask

  task automatic test_misaligned();
    drive(0, 0, 0, 1, 32'h42, 0, 32'h0);
    tick();
    total++;
    if ({fault, cause, tval, imem_adr, ifid_valid} !== {1'b1, 4'd0, 32'h42, 32'h44, 1'b0}) begin
      bad++;
      $display("FAIL misaligned: f=%b c=%h tval=%h adr=%h v=%b want f=1 c=0 tval=42 adr=44 v=0",
               fault, cause, tval, imem_adr, ifid_valid);
    end
    drive(0, 0, 0, 0, 32'h0, 0, 32'h0);
    for (int i = 0; i < 2; i++) begin
      tick();
      total++;
      if ({fault, ifid_valid, imem_adr, ifid_instr, tval} !== {1'b0, 1'b0, 32'h44, NOP, 32'h42}) begin
        bad++;
        $display("FAIL wait_trap %0d: f=%b v=%b adr=%h instr=%h tval=%h want f=0 v=0 adr=44 nop tval=42",
                 i, fault, ifid_valid, imem_adr, ifid_instr, tval);
      end
    end
    drive(0, 0, 0, 0, 32'h0, 1, 32'h103);
    tick();
    total++;
    if ({imem_adr, ifid_valid} !== {32'h100, 1'b0}) begin
      bad++;
      $display("FAIL trap_entry: adr=%h v=%b want adr=100 v=0", imem_adr, ifid_valid);
    end
    drive(0, 0, 0, 0, 32'h0, 0, 32'h0);
    tick();
    total++;
    if ({ifid_valid, ifid_pc, fault} !== {1'b1, 32'h100, 1'b0}) begin
      bad++;
      $display("FAIL trap_resume: v=%b pc=%h f=%b want v=1 pc=100 f=0", ifid_valid, ifid_pc, fault);
    end
  endtask

  task automatic test_access_fault();
    drive(0, 0, 0, 1, 32'h000F_FFFC, 0, 32'h0);
    tick();
    total++;
    if (imem_adr !== 32'h000F_FFFC) begin
      bad++;
      $display("FAIL access_redirect: adr=%h want 000ffffc", imem_adr);
    end
    drive(0, 0, 0, 0, 32'h0, 0, 32'h0);
    tick();
    total++;
    if ({ifid_valid, ifid_pc, ifid_instr, imem_adr} !== {1'b1, 32'h000F_FFFC, mem_word(32'h000F_FFFC), 32'h0010_0000}) begin
      bad++;
      $display("FAIL access_last_word: v=%b pc=%h instr=%h adr=%h want pc=000ffffc adr=00100000",
               ifid_valid, ifid_pc, ifid_instr, imem_adr);
    end
    tick();
    total++;
    if ({fault, cause, tval, imem_adr, ifid_valid} !== {1'b1, 4'd1, 32'h0010_0000, 32'h0010_0000, 1'b0}) begin
      bad++;
      $display("FAIL access_fault: f=%b c=%h tval=%h adr=%h v=%b want f=1 c=1 tval=00100000 adr=00100000 v=0",
               fault, cause, tval, imem_adr, ifid_valid);
    end
    tick();
    total++;
    if ({fault, imem_adr} !== {1'b0, 32'h0010_0000}) begin
      bad++;
      $display("FAIL access_pulse: f=%b adr=%h want f=0 adr=00100000", fault, imem_adr);
    end
  endtask

  task automatic test_trap_over_redirect();
    drive(0, 0, 0, 1, 32'h80, 1, 32'h200);
    tick();
    total++;
    if (imem_adr !== 32'h200) begin
      bad++;
      $display("FAIL trap_priority: adr=%h want 00000200", imem_adr);
    end
    drive(0, 0, 0, 0, 32'h0, 0, 32'h0);
    tick();
    total++;
    if ({ifid_valid, ifid_pc} !== {1'b1, 32'h200}) begin
      bad++;
      $display("FAIL trap_priority_run: v=%b pc=%h want v=1 pc=200", ifid_valid, ifid_pc);
    end
    drive(0, 0, 0, 1, 32'h81, 0, 32'h0);
    tick();
    drive(0, 0, 0, 0, 32'h0, 0, 32'h0);
    tick();
    drive(1, 0, 0, 0, 32'h0, 0, 32'h0);
    tick();
    total++;
    if ({imem_adr, ifid_valid, ifid_pc, ifid_pc4, ifid_instr, fault, cause, tval, count} !==
        {32'h0, 1'b0, 32'h0, 32'h0, NOP, 1'b0, 4'h0, 32'h0, 32'h0}) begin
      bad++;
      $display("FAIL reset_in_wait: adr=%h v=%b pc=%h pc4=%h instr=%h f=%b c=%h tval=%h cnt=%h want reset values",
               imem_adr, ifid_valid, ifid_pc, ifid_pc4, ifid_instr, fault, cause, tval, count);
    end
    drive(0, 0, 0, 0, 32'h0, 0, 32'h0);
    tick();
    total++;
    if ({ifid_valid, ifid_pc, ifid_instr} !== {1'b1, 32'h0, 32'h00500093}) begin
      bad++;
      $display("FAIL reset_resume: v=%b pc=%h instr=%h want v=1 pc=0 instr=00500093", ifid_valid, ifid_pc, ifid_instr);
    end
  endtask

  task automatic test_random();
    logic [31:0] target;
    for (int i = 0; i < 600; i++) begin
      case ($urandom_range(0, 3))
        0: target = 32'($urandom_range(0, 255)) << 2;
        1: target = (32'($urandom_range(0, 255)) << 2) | 32'($urandom_range(1, 3));
        2: target = 32'h000F_FFF0 + (32'($urandom_range(0, 5)) << 2);
        default: target = $urandom & 32'hFFFF_FFFC;
      endcase
      drive($urandom_range(0, 99) == 0, $urandom_range(0, 4) == 0, $urandom_range(0, 7) == 0,
            $urandom_range(0, 9) == 0, target, $urandom_range(0, 24) == 0, 32'($urandom_range(0, 4095)));
      tick();
      total++;
      if ({imem_adr, ifid_valid, ifid_pc, ifid_pc4, ifid_instr, fault, cause, tval, count} !==
          {m_pc, m_valid, m_ipc, m_ipc4, m_instr, m_fault, m_cause, m_tval, m_count}) begin
        bad++;
        $display("FAIL random cycle %0d: dut adr=%h v=%b pc=%h pc4=%h instr=%h f=%b c=%h tval=%h cnt=%h model adr=%h v=%b pc=%h pc4=%h instr=%h f=%b c=%h tval=%h cnt=%h",
                 i, imem_adr, ifid_valid, ifid_pc, ifid_pc4, ifid_instr, fault, cause, tval, count,
                 m_pc, m_valid, m_ipc, m_ipc4, m_instr, m_fault, m_cause, m_tval, m_count);
      end
    end
  endtask

  initial begin
    drive(1, 0, 0, 0, 32'h0, 0, 32'h0);
    #2;
    test_reset();
    test_free_run();
    test_stall();
    test_redirect_stall();
    test_misaligned();
    test_access_fault();
    test_trap_over_redirect();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction-fetch stage directly upstream of the byte-addressed, little-endian, combinational-read instruction memory.
- Owns the PC register and drives the memory address.
- Captures the returned 32-bit instruction into the IF/ID pipeline register.
- Handles stall, flush, branch/jump redirect, trap entry, and fetch faults (misaligned target, out-of-range PC), reporting faults with RISC-V mcause codes.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- IMEM_BYTES, 1<<20, size of instruction memory in bytes; a fetch at PC > IMEM_BYTES-4 is an access fault.
- NOP_INSTR, 32'h0000_0013, instruction (addi x0,x0,0) placed in IF/ID on a bubble.

Ports:
- i_clk  in  1  clock; all state updates on rising edge.
- i_rst  in  1  synchronous, active-high reset.
- i_stall  in  1  hold PC and IF/ID (hazard unit).
- i_flush  in  1  replace IF/ID contents with a bubble this cycle.
- i_redirect_valid  in  1  branch/jump taken.
- i_redirect_pc  in  32  redirect target.
- i_trap_valid  in  1  trap/exception entry or mret.
- i_trap_pc  in  32  trap vector / return PC.
- o_imem_adr  out  32  address to instruction memory; equals current PC (combinational from PC register).
- i_imem_instr  in  32  instruction returned combinationally for o_imem_adr.
- o_if_id_valid  out  1  IF/ID holds a real instruction.
- o_if_id_pc  out  32  PC of IF/ID instruction.
- o_if_id_pc_plus4  out  32  PC+4 of IF/ID instruction.
- o_if_id_instr  out  32  IF/ID instruction.
- o_fault  out  1  one-cycle pulse: fetch fault detected.
- o_fault_cause  out  4  0 = instruction address misaligned, 1 = instruction access fault.
- o_fault_tval  out  32  faulting address; held until the next fault.
- o_fetch_count  out  32  number of valid instructions written to IF/ID.

Behaviour:
- State machine with two states.
  - RUN: normal fetch.
  - WAIT_TRAP: fault outstanding; PC frozen; IF/ID fed bubbles until i_trap_valid.
- Reset (i_rst=1 at an edge) sets:
  - PC = RESET_PC, state = RUN.
  - o_if_id_valid = 0, o_if_id_instr = NOP_INSTR, o_if_id_pc = 0, o_if_id_pc_plus4 = 0.
  - o_fault = 0, o_fault_cause = 0, o_fault_tval = 0, o_fetch_count = 0.
  - Reset mid-operation discards everything, including a pending WAIT_TRAP.
- Per-edge priority, highest first: i_rst > i_trap_valid > i_redirect_valid > (state WAIT_TRAP) > access-fault check > i_flush > i_stall > normal advance.
- Trap:
  - PC <= {i_trap_pc[31:2], 2'b00}, state <= RUN, IF/ID <= bubble.
  - Accepted in either state and regardless of stall.
- Redirect, aligned target (i_redirect_pc[1:0] == 0): PC <= target; IF/ID <= bubble, because the instruction fetched this cycle is wrong-path. Overrides stall.
- Redirect, misaligned target:
  - PC unchanged, IF/ID <= bubble, state <= WAIT_TRAP.
  - o_fault = 1, cause 0, tval = i_redirect_pc.
- WAIT_TRAP without trap: PC held, IF/ID <= bubble, o_fault = 0.
- Access-fault check (RUN, not stalled, PC > IMEM_BYTES-4):
  - IF/ID <= bubble, state <= WAIT_TRAP.
  - o_fault = 1, cause 1, tval = PC.
- Flush without redirect/trap: IF/ID <= bubble; PC advances by 4 unless i_stall=1, in which case PC is held.
- Stall without flush/redirect/trap: PC and IF/ID unchanged; fetch count unchanged.
- Normal advance:
  - IF/ID <= {valid=1, PC, PC+4, i_imem_instr}; PC <= PC+4.
  - o_fetch_count increments.
- A bubble is always valid=0, instr=NOP_INSTR, with pc/pc_plus4 of the slot it replaces.
- Arithmetic wrap:
  - PC+4 is modulo 2^32 (0xFFFF_FFFC -> 0x0000_0000); with the default IMEM_BYTES the access fault fires first.
  - o_fetch_count wraps 0xFFFF_FFFF -> 0.
- Latency: an instruction at address A appears in IF/ID one edge after PC = A with no stall.
- o_fault is high for exactly one cycle per fault event; cause/tval are registered with it.

Test Plan:
- Reset, then free-run 4 cycles with memory words 0x00500093, 0x00A00113, 0x002081B3, 0x00000013 at 0x0/0x4/0x8/0xC -> IF/ID shows pc 0x0, 0x4, 0x8, 0xC in successive cycles with matching instrs; o_fetch_count = 4.
- i_stall high 3 cycles at PC = 0x8 -> PC and IF/ID frozen (pc 0x4 instr 0x00A00113); count unchanged; resumes with 0x8 next.
- Redirect to 0x40 asserted together with i_stall -> next cycle PC = 0x40, IF/ID bubble (valid 0, instr 0x00000013); the following cycle IF/ID pc = 0x40.
- Redirect to 0x42 -> o_fault pulse, cause 0, tval 0x42, bubbles while waiting; i_trap_valid with i_trap_pc 0x103 -> PC = 0x100, state RUN.
- Redirect to 0x000FFFFC, run 2 cycles -> instr at 0xFFFFC delivered; then PC 0x100000 raises o_fault cause 1, tval 0x00100000, PC held.
- Simultaneous i_trap_valid (0x200) and i_redirect_valid (0x80) -> PC = 0x200; assert i_rst during WAIT_TRAP -> PC = RESET_PC, all outputs at reset values.
